// File: rtl/icache_direct.sv
// Direct-mapped instruction cache between the fetch unit (IF) and the memory
// controller (MC). Hits answer in one cycle; a miss fetches a whole aligned
// block from MC, installs it, and answers from the incoming block.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   clear_in                 : pipeline flush; drops an in-flight answer
//   IF2IC_en / IF2IC_pc      : fetch request (taken only while IC2IF_rdy)
//   IC2IF_rdy                : cache idle and able to take a request
//   IC2IF_en / IC2IF_inst    : one-cycle response pulse and instruction word
//   IC2MC_en / IC2MC_addr    : block request, held until MC answers
//   MC2IC_en / MC2IC_block   : one-cycle fill pulse and block data (word k at [32k+31:32k])
module icache_direct #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLK_WIDTH   = 2,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear_in,
  input  logic                       IF2IC_en,
  input  logic [ADDR_WIDTH-1:0]      IF2IC_pc,
  output logic                       IC2IF_rdy,
  output logic                       IC2IF_en,
  output logic [31:0]                IC2IF_inst,
  output logic                       IC2MC_en,
  output logic [ADDR_WIDTH-1:0]      IC2MC_addr,
  input  logic                       MC2IC_en,
  input  logic [(32<<BLK_WIDTH)-1:0] MC2IC_block
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLK_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int BLOCK_W   = 32 << BLK_WIDTH;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tag_mem  [LINES];
  logic [BLOCK_W-1:0]   data_mem [LINES];

  logic [BLK_WIDTH-1:0]   req_off, miss_off;
  logic [INDEX_WIDTH-1:0] req_idx, miss_idx;
  logic [TAG_WIDTH-1:0]   req_tag, miss_tag;
  logic                   drop;
  logic                   req_take, req_hit, fill_fire;

  // Byte-offset bits of the pc never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = ^IF2IC_pc[1:0];

  assign req_off = IF2IC_pc[BLK_WIDTH+1:2];
  assign req_idx = IF2IC_pc[BLK_WIDTH+INDEX_WIDTH+1:BLK_WIDTH+2];
  assign req_tag = IF2IC_pc[ADDR_WIDTH-1:ADDR_WIDTH-TAG_WIDTH];

  assign req_take  = (state == IDLE) && IF2IC_en && !clear_in;
  assign req_hit   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill_fire = rdy_in && (state == MISS) && MC2IC_en;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_take && !req_hit) state_nxt = MISS;
      MISS: if (MC2IC_en)             state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Output logic (combinational part)
  always_comb begin
    IC2IF_rdy = (state == IDLE);
  end

  // Registered outputs, miss bookkeeping and drop flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      IC2IF_en   <= 1'b0;
      IC2IF_inst <= '0;
      IC2MC_en   <= 1'b0;
      IC2MC_addr <= '0;
      drop       <= 1'b0;
      miss_off   <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
    end else if (rdy_in) begin
      IC2IF_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_take) begin
            if (req_hit) begin
              IC2IF_en   <= 1'b1;
              IC2IF_inst <= data_mem[req_idx][{req_off, 5'd0} +: 32];
            end else begin
              miss_off   <= req_off;
              miss_idx   <= req_idx;
              miss_tag   <= req_tag;
              IC2MC_en   <= 1'b1;
              IC2MC_addr <= {req_tag, req_idx, {(BLK_WIDTH+2){1'b0}}};
            end
          end
        end
        MISS: begin
          if (MC2IC_en) begin
            // Request drops on the fill edge so MC never sees a stale request.
            IC2MC_en <= 1'b0;
            drop     <= 1'b0;
            if (!drop && !clear_in) begin
              IC2IF_en   <= 1'b1;
              IC2IF_inst <= MC2IC_block[{miss_off, 5'd0} +: 32];
            end
          end else if (clear_in) begin
            drop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Valid bits are the only array state that reset touches.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)         valid <= '0;
    else if (fill_fire) valid[miss_idx] <= 1'b1;
  end

  // Tag and data arrays: written only on a fill, a flush never cancels it.
  always_ff @(posedge clk_in) begin
    if (fill_fire) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= MC2IC_block;
    end
  end

endmodule
